// File: rtl/cla_nibble_subtractor.sv
// cla_nibble_subtractor
//
// Multi-cycle subtractor that computes diff = (a - b - bin) mod 2^WIDTH, one 4-bit slice per
// clock. Each slice resolves its borrows with lookahead logic:
//   g = ~a & b   (the slice generates a borrow)
//   p = ~(a ^ b) (the slice passes an incoming borrow through)
// The slice borrow-out is registered and becomes the next slice's borrow-in.
//
// A controller drives it with a start/done handshake:
//   - start is sampled only in IDLE. An accepted start latches a, b and bin.
//   - busy is high for the N = WIDTH/4 slice cycles.
//   - done pulses for one cycle. diff, bout and ovf are updated at the edge where done
//     rises, and they keep that value until the next operation completes.
//
// Optional feature: define CLA_SUB_OVERFLOW_EN to compute the signed-overflow flag ovf.
// Without it, ovf is tied to 0 and no overflow logic is built.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; aborts a running operation with no done pulse
//   start - operation request
//   a     - minuend (WIDTH bits)
//   b     - subtrahend (WIDTH bits)
//   bin   - borrow-in
//   busy  - high while the slices are being processed
//   done  - one-cycle pulse that marks a valid result
//   diff  - difference, (a - b - bin) mod 2^WIDTH
//   bout  - borrow-out, unsigned underflow (a < b + bin)
//   ovf   - signed overflow (always 0 unless CLA_SUB_OVERFLOW_EN is defined)
module cla_nibble_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned N    = WIDTH / 4;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              borrow_q;
    logic [WIDTH-1:0]  res_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  diff_q;
    logic              bout_q;

    // Current slice operands, selected from the latched operands by the slice index.
    logic [3:0]        slice_a;
    logic [3:0]        slice_b;
    logic [3:0]        g;
    logic [3:0]        p;
    logic [4:0]        c;
    logic [3:0]        slice_diff;
    logic [WIDTH-1:0]  res_next;
    logic              last_slice;

    always_comb begin
        slice_a = a_q[{idx_q, 2'b00} +: 4];
        slice_b = b_q[{idx_q, 2'b00} +: 4];
        g       = ~slice_a & slice_b;
        p       = ~(slice_a ^ slice_b);

        // Every borrow is a flat sum of products of g, p and c[0], so no borrow
        // ripples through the bits of the slice.
        c[0] = borrow_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);

        slice_diff = slice_a ^ slice_b ^ c[3:0];

        // res_q with the current slice written in. On the last slice this is the full result.
        res_next = res_q;
        res_next[{idx_q, 2'b00} +: 4] = slice_diff;

        last_slice = (idx_q == IdxW'(N - 1));
    end

`ifdef CLA_SUB_OVERFLOW_EN
    logic ovf_q;
    logic ovf_next;

    // Signed overflow is only possible when the operand signs differ. It has occurred
    // when the result sign differs from the minuend sign.
    always_comb begin
        ovf_next = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (res_next[WIDTH-1] != a_q[WIDTH-1]);
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            res_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef CLA_SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    res_q    <= res_next;
                    borrow_q <= c[4];
                    idx_q    <= idx_q + 1'b1;
                    if (last_slice) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= res_next;
                        bout_q  <= c[4];
`ifdef CLA_SUB_OVERFLOW_EN
                        ovf_q   <= ovf_next;
`endif
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_cla_nibble_subtractor.sv
// Testbench for cla_nibble_subtractor (WIDTH=16).
// Expected results are pushed into a queue when each operation is issued. A separate monitor
// pops one entry and compares it each time done is seen.
module tb_cla_nibble_subtractor;

    localparam int W = 16;
    localparam int N = W / 4;
`ifdef CLA_SUB_OVERFLOW_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         bin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    time  done_t[$];

    cla_nibble_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] d, input logic bo, input logic ov);
        exp_t e;
        e.d  = d;
        e.bo = bo;
        e.ov = OvfEn ? ov : 1'b0;
        sb.push_back(e);
    endtask

    // Monitor: compares every done pulse against the oldest pending expectation.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            n_done++;
            done_t.push_back($time);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with diff=%0h, expected no done", diff);
            end else begin
                e = sb.pop_front();
                chk("diff", 32'(diff), 32'(e.d));
                chk("bout", 32'(bout), 32'(e.bo));
                chk("ovf", 32'(ovf), 32'(e.ov));
            end
        end
    end

    // Issues one operation and checks busy, the done latency and the return to IDLE.
    // The result values themselves are checked by the monitor.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        int lat;
        lat = -1;
        @(negedge clk);
        a = ta;
        b = tb_v;
        bin = tbin;
        start = 1'b1;
        push_exp(ed, eb, eo);
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = 1; i <= N + 4; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("done_latency", 32'(lat), 32'(N));
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int base;

        // Reset state.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-computed results.
        run_op(16'h1234, 16'h0FFF, 1'b0, 16'h0235, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);

        // A second start during RUN and operand changes after the start edge are ignored.
        base = n_done;
        @(negedge clk);
        a = 16'h5A5A;
        b = 16'h1234;
        bin = 1'b1;
        start = 1'b1;
        push_exp(16'h4825, 1'b0, 1'b0);
        @(posedge clk);           // edge k
        #1 start = 1'b0;
        @(negedge clk);
        a = 16'h0000;
        b = 16'hFFFF;
        bin = 1'b0;
        @(negedge clk);
        start = 1'b1;             // sampled at edge k+2
        @(posedge clk);
        #1 start = 1'b0;
        a = 16'h1111;
        @(posedge clk);           // edge k+3
        @(posedge clk);           // edge k+4
        #1;
        chk("midrun_done_k4", 32'(done), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("midrun_single_done", 32'(n_done - base), 32'd1);

        // Reset in the middle of RUN aborts the operation without a done pulse.
        base = n_done;
        @(negedge clk);
        a = 16'h2222;
        b = 16'h1111;
        bin = 1'b0;
        start = 1'b1;
        @(posedge clk);           // edge k
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(n_done - base), 32'd0);
        run_op(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0);

        // Back-to-back operation with start held high: one accept every N+2 edges.
        base = n_done;
        done_t.delete();
        push_exp(16'h8000, 1'b1, 1'b1);
        push_exp(16'hFFFE, 1'b1, 1'b0);
        push_exp(16'h9ABB, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'h7FFF;
        b = 16'hFFFF;
        bin = 1'b0;
        start = 1'b1;
        @(posedge clk);           // accept op0
        #1;
        a = 16'h0003;
        b = 16'h0005;
        bin = 1'b0;
        repeat (N + 2) @(posedge clk);  // accept op1
        #1;
        chk("b2b_hold_diff", 32'(diff), 32'h8000);
        chk("b2b_hold_bout", 32'(bout), 32'd1);
        a = 16'hABCD;
        b = 16'h1111;
        bin = 1'b1;
        repeat (N + 2) @(posedge clk);  // accept op2
        #1 start = 1'b0;
        repeat (N + 4) @(posedge clk);
        #1;
        chk("b2b_done_count", 32'(n_done - base), 32'd3);
        if (done_t.size() == 3) begin
            chk("b2b_period_0", 32'(done_t[1] - done_t[0]), 32'((N + 2) * 10));
            chk("b2b_period_1", 32'(done_t[2] - done_t[1]), 32'((N + 2) * 10));
        end else begin
            chk("b2b_pulses", 32'(done_t.size()), 32'd3);
        end

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Keeps the run bounded if the stimulus stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "timeout");
    end

endmodule
